fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch front end for the pipelined MIPS core. It sits directly upstream of `icache`: it owns the PC, drives `imemREN`/`imemaddr` on the datapath–cache interface and consumes `ihit`/`imemload`. Fetched words go into a small in-order prefetch queue that decouples icache stalls from decode back-pressure. Branch/jump redirects flush the queue. A halt request stops fetching.

## Interface
Parameters:
- `PC_INIT`, default `32'h0000_0000`: PC value after reset; bits [1:0] must be 0.
- `QDEPTH`, default 2: prefetch queue entries; legal values are 2, 4, 8.

Ports:
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `ihit` in 1: icache hit for the current `imemaddr`.
- `imemload` in 32: instruction word from icache, valid when `ihit`=1.
- `imemREN` out 1: fetch request to icache.
- `imemaddr` out 32: fetch address, equal to the current PC.
- `redirect` in 1: branch/jump taken, resolved downstream.
- `redirect_pc` in 32: new PC; bits [1:0] are ignored and forced to 0.
- `halt` in 1: stop fetching; sticky until reset.
- `id_ready` in 1: decode accepts the head entry this cycle.
- `if_valid` out 1: queue is non-empty.
- `if_instr` out 32: head instruction.
- `if_pc` out 32: head PC.
- `if_npc` out 32: head PC + 4.
- `fetch_cnt` out 32: perf counter, see Configuration.
- `stall_cnt` out 32: perf counter, see Configuration.

## Operation
- State:
  - `pc` register.
  - Circular queue of `QDEPTH` entries {pc, instr}, with `rd_ptr`, `wr_ptr` and `count` (width $clog2(QDEPTH)+1).
  - `halted` flag.
- Request rule: `imemREN` = !RST && !halted && !redirect && (count < QDEPTH). `imemaddr` = `pc` at all times.
- Enqueue occurs when `imemREN` && `ihit`:
  - Write {pc, imemload} at `wr_ptr`.
  - `wr_ptr` advances modulo QDEPTH.
  - `pc` <= pc + 4; the adder wraps modulo 2^32 and no carry out is kept.
- Dequeue occurs when `if_valid` && `id_ready`: `rd_ptr` advances modulo QDEPTH.
- Simultaneous enqueue and dequeue: `count` is unchanged and both pointers advance.
- Full rule: when count == QDEPTH, no request is made, even if a dequeue happens in the same cycle. The full check uses registered `count` only.
- Redirect has the highest priority over enqueue, dequeue and halt in the same cycle:
  - `count`, `rd_ptr` and `wr_ptr` go to 0.
  - `pc` <= {redirect_pc[31:2], 2'b00}.
  - No enqueue that cycle, because `imemREN` is low.
  - A dequeue in that same cycle has no effect.
- Halt:
  - `halt`=1 sets `halted`. From the next cycle `imemREN`=0 and `pc` is frozen.
  - Queued entries still drain to decode.
  - A redirect after halt updates `pc` and flushes, but fetching stays stopped.
- Outputs `if_instr`, `if_pc` and `if_npc` come from entry `rd_ptr`. They are don't-care when `if_valid`=0.

## Timing
- Reset: while `RST`=1 at a rising edge:
  - `pc` <= PC_INIT; `count`, `rd_ptr`, `wr_ptr` <= 0; `halted` <= 0; counters <= 0.
  - Outputs after reset: `imemREN`=0 while RST is high, then 1 in the first cycle after; `imemaddr`=PC_INIT; `if_valid`=0; `if_instr`, `if_pc`, `if_npc` don't-care; `fetch_cnt`=`stall_cnt`=0.
- Reset asserted mid-operation discards all queued entries and any pending halt in that cycle.
- Fetch latency:
  - An `ihit` in cycle N makes the entry visible with `if_valid`=1 in cycle N+1.
  - With a continuous hit and `id_ready`=1, throughput is one instruction per cycle with no bubbles.
- A miss (`imemREN`=1, `ihit`=0) holds `pc` and `imemaddr` stable until the hit.
- Redirect in cycle N: `imemaddr` = redirect target and `if_valid`=0 in cycle N+1. The first redirected instruction is available no earlier than N+2.
- `if_*` outputs are registered-path only. There is no combinational path from `ihit` or `imemload` to `if_*`.

## Configuration
- `FETCH_PERF_EN` defined:
  - `fetch_cnt` increments on every enqueue.
  - `stall_cnt` increments on every cycle with `imemREN`=1 && `ihit`=0.
  - Both counters are 32 bits and wrap at 2^32.
  - Both are cleared only by reset; redirect and halt do not clear them.
- `FETCH_PERF_EN` not defined: no counter registers exist; `fetch_cnt` and `stall_cnt` are tied to 0. The ports exist in both builds.

## Test plan
- Reset with PC_INIT=0x100, then `ihit`=1 and `id_ready`=1 for 4 cycles -> `if_pc` sequence 0x100, 0x104, 0x108, 0x10C from cycle 2; `if_npc` = `if_pc`+4.
- `id_ready`=0 with `ihit`=1, QDEPTH=2 -> after 2 enqueues `imemREN`=0 and `imemaddr`=0x108. One dequeue frees an entry; `imemREN` returns the next cycle.
- Miss for 3 cycles at 0x104 -> `imemaddr` is held at 0x104, `pc` is unchanged, and `stall_cnt`=3 with `FETCH_PERF_EN` (0 without).
- Queue holding 2 entries, redirect with `redirect_pc`=0x2003 -> next cycle `if_valid`=0 and `imemaddr`=0x2000; the old entries are never presented.
- Redirect and `id_ready` and `ihit` all asserted in the same cycle -> flush wins and `fetch_cnt` does not increment.
- `halt` asserted with 1 entry queued -> `imemREN`=0 next cycle, the entry still drains, then `if_valid` stays 0. Asserting `RST` -> fetching resumes at PC_INIT.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, requests words from icache and buffers them
// in an in-order prefetch queue. Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          QDEPTH  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

  logic [31:0]      pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             halted;

  logic [31:0] q_pc    [QDEPTH];
  logic [31:0] q_instr [QDEPTH];

  logic req;
  logic enq;
  logic deq;
  logic stall;

  // QDEPTH is a power of two, so the natural pointer wrap is the modulo.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Full check looks at registered count only, so a same-cycle dequeue never unblocks a request.
  assign req      = !RST && !halted && !redirect && (count < FULL);
  assign enq      = req && ihit;
  assign stall    = req && !ihit;
  assign deq      = if_valid && id_ready;

  assign imemREN  = req;
  assign imemaddr = pc;

  // Control state
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc     <= PC_INIT;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      halted <= 1'b0;
    end else begin
      if (halt) halted <= 1'b1;
      if (redirect) begin
        pc     <= word_align(redirect_pc);
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) begin
          wr_ptr <= ptr_inc(wr_ptr);
          pc     <= pc + 32'd4;
        end
        if (deq) rd_ptr <= ptr_inc(rd_ptr);
        case ({enq, deq})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage: data only, never reset
  always_ff @(posedge CLK) begin
    if (enq) begin
      q_pc[wr_ptr]    <= pc;
      q_instr[wr_ptr] <= imemload;
    end
  end

  assign if_valid = (count != '0);
  assign if_pc    = q_pc[rd_ptr];
  assign if_instr = q_instr[rd_ptr];
  assign if_npc   = q_pc[rd_ptr] + 32'd4;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_q;
  logic [31:0] stall_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      if (enq)   fetch_q <= fetch_q + 32'd1;
      if (stall) stall_q <= stall_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_q;
  assign stall_cnt = stall_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign fetch_cnt    = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, checked against a
// queue-based reference model of the fetch front end.
module tb_fetch_stage;

  localparam logic [31:0] PC_INIT = 32'h0000_0100;
  localparam int          QDEPTH  = 2;

  logic        CLK = 1'b0;
  logic        RST, ihit, redirect, halt, id_ready;
  logic [31:0] imemload, redirect_pc;
  logic        imemREN, if_valid;
  logic [31:0] imemaddr, if_instr, if_pc, if_npc, fetch_cnt, stall_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc     = PC_INIT;
  logic        m_halted = 1'b0;
  logic [31:0] m_fc     = '0;
  logic [31:0] m_sc     = '0;

  fetch_stage #(.PC_INIT(PC_INIT), .QDEPTH(QDEPTH)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_npc(if_npc), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_req();
    return !RST && !m_halted && !redirect && (mq.size() < QDEPTH);
  endfunction

  // Advance the reference model by one clock using the inputs currently driven.
  task automatic model_step();
    logic r, e, d;
    ent_t n;
    r = model_req();
    e = r && ihit;
    d = (mq.size() != 0) && id_ready;
    if (RST) begin
      mq.delete();
      m_pc = PC_INIT; m_halted = 1'b0; m_fc = '0; m_sc = '0;
    end else begin
      if (e) m_fc = m_fc + 1;
      if (r && !ihit) m_sc = m_sc + 1;
      if (halt) m_halted = 1'b1;
      if (redirect) begin
        mq.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (d) void'(mq.pop_front());
        if (e) begin
          n.pc = m_pc; n.instr = imemload;
          mq.push_back(n);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic check_state();
    check("imemaddr", imemaddr, m_pc);
    check("if_valid", {31'b0, if_valid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      check("if_pc", if_pc, mq[0].pc);
      check("if_instr", if_instr, mq[0].instr);
      check("if_npc", if_npc, mq[0].pc + 32'd4);
    end
`ifdef FETCH_PERF_EN
    check("fetch_cnt", fetch_cnt, m_fc);
    check("stall_cnt", stall_cnt, m_sc);
`else
    check("fetch_cnt", fetch_cnt, 32'd0);
    check("stall_cnt", stall_cnt, 32'd0);
`endif
  endtask

  // One clock: drive inputs after the previous edge, check the request, step, check state.
  task automatic cyc(input logic r, input logic h, input logic [31:0] ins, input logic rd,
                     input logic [31:0] rpc, input logic hl, input logic ry);
    RST = r; ihit = h; imemload = ins; redirect = rd; redirect_pc = rpc; halt = hl; id_ready = ry;
    #1;
    check("imemREN", {31'b0, imemREN}, {31'b0, model_req()});
    model_step();
    @(posedge CLK);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] fc_before;
    RST = 1'b1; ihit = 1'b0; imemload = '0; redirect = 1'b0;
    redirect_pc = '0; halt = 1'b0; id_ready = 1'b0;
    @(posedge CLK);
    #1;

    // Reset state and streaming fetch
    do_reset();
    check("rst_addr", imemaddr, 32'h100);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_fcnt", fetch_cnt, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 32'hA000_0000 + i, 1'b0, 32'h0, 1'b0, 1'b1);
      check("seq_pc", if_pc, 32'h100 + 4 * i);
      check("seq_npc", if_npc, 32'h104 + 4 * i);
    end

    // Full queue blocks requests; one dequeue reopens them
    do_reset();
    cyc(1'b0, 1'b1, 32'h11, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h22, 1'b0, 32'h0, 1'b0, 1'b0);
    check("full_ren", {31'b0, imemREN}, 32'd0);
    check("full_addr", imemaddr, 32'h108);
    cyc(1'b0, 1'b1, 32'h33, 1'b0, 32'h0, 1'b0, 1'b1);
    check("refill_ren", {31'b0, imemREN}, 32'd1);

    // Miss holds the address
    do_reset();
    cyc(1'b0, 1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'hDEAD, 1'b0, 32'h0, 1'b0, 1'b1);
      check("miss_addr", imemaddr, 32'h104);
    end
`ifdef FETCH_PERF_EN
    check("miss_stall", stall_cnt, 32'd3);
`else
    check("miss_stall", stall_cnt, 32'd0);
`endif

    // Redirect flushes a full queue and beats a simultaneous hit and dequeue
    do_reset();
    cyc(1'b0, 1'b1, 32'h55, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h66, 1'b0, 32'h0, 1'b0, 1'b0);
    fc_before = fetch_cnt;
    cyc(1'b0, 1'b1, 32'h77, 1'b1, 32'h2003, 1'b0, 1'b1);
    check("redir_valid", {31'b0, if_valid}, 32'd0);
    check("redir_addr", imemaddr, 32'h2000);
    check("redir_fcnt", fetch_cnt, fc_before);
    cyc(1'b0, 1'b1, 32'h88, 1'b0, 32'h0, 1'b0, 1'b0);
    check("redir_first", if_pc, 32'h2000);

    // PC adder wraps at the top of the address space
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check("wrap_top", imemaddr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b1, 32'h99, 1'b0, 32'h0, 1'b0, 1'b0);
    check("wrap_zero", imemaddr, 32'h0);

    // Halt stops fetching, queued entry drains, reset resumes
    do_reset();
    cyc(1'b0, 1'b1, 32'hAA, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("halt_ren", {31'b0, imemREN}, 32'd0);
    check("halt_head", if_pc, 32'h100);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 32'hBB, 1'b0, 32'h0, 1'b0, 1'b1);
      check("halt_drained", {31'b0, if_valid}, 32'd0);
    end
    do_reset();
    cyc(1'b0, 1'b1, 32'hCC, 1'b0, 32'h0, 1'b0, 1'b1);
    check("resume_pc", if_pc, 32'h100);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 64) == 0, ($urandom % 10) < 7, $urandom, ($urandom % 10) == 0,
          $urandom, ($urandom % 60) == 0, ($urandom % 10) < 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
